// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_access_unit_pkg                                              |
// | Shared types and fault helper for the data-memory access unit.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10,
      RESP = 2'b11
   } mau_state_e;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      NONE     = 2'b00,
      MMU      = 2'b01,
      MISALIGN = 2'b10,
      TIMEOUT  = 2'b11
   } mau_fault_e;

   // The reserved size encoding is treated as misaligned so it never reaches the bus.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic result;
      case (size)
         BYTE:    result = 1'b0;
         HALF:    result = offset[0];
         WORD:    result = (offset != 2'b00);
         default: result = 1'b1;
      endcase
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mau_data_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mau_data_align                                                   |
// | Store-lane replication, byte enables and load shift/extension.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mau_data_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        is_unsigned,
   input  logic [31:0] store_data,
   input  logic [31:0] bus_rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] bus_wdata,
   output logic [31:0] load_data
);

   logic [31:0] w_shifted;

   assign w_shifted = bus_rdata >> {offset, 3'b000};

   always_comb begin
      byte_en   = 4'b0000;
      bus_wdata = 32'h0000_0000;
      load_data = 32'h0000_0000;
      case (size)
         BYTE: begin
            byte_en   = 4'b0001 << offset;
            bus_wdata = {4{store_data[7:0]}};
            load_data = {{24{~is_unsigned & w_shifted[7]}}, w_shifted[7:0]};
         end
         HALF: begin
            byte_en   = 4'b0011 << offset;
            bus_wdata = {2{store_data[15:0]}};
            load_data = {{16{~is_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         end
         WORD: begin
            byte_en   = 4'b1111;
            bus_wdata = store_data;
            // A legal word access has offset 0, so the shifted word is the bus word.
            load_data = w_shifted;
         end
         default: begin
            byte_en   = 4'b0000;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_access_unit                                                  |
// | Load/store sequencer: fault check, bus handshake, timeout abort. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] address_i,
   input  logic        mmu_exception_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        fault_o,
   output logic [1:0]  fault_code_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [1:0]  c_ST_IDLE      = IDLE;
   localparam logic [1:0]  c_ST_REQ       = REQ;
   localparam logic [1:0]  c_ST_WAIT      = WAIT;
   localparam logic [1:0]  c_ST_RESP      = RESP;
   localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_fault_code;
   logic [31:0] r_rdata;
   logic [15:0] r_count;

   logic [1:0]  w_fault_code;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_load_data;

   always_comb begin
      w_fault_code = NONE;
      if (mmu_exception_i) begin
         w_fault_code = MMU;
      end else if (is_misaligned(size_i, address_i[1:0])) begin
         w_fault_code = MISALIGN;
      end
   end

   // Lanes are computed from latched request fields so the bus stays stable in REQ.
   mau_data_align u_align (
      .size        (r_size),
      .offset      (r_addr[1:0]),
      .is_unsigned (r_unsigned),
      .store_data  (r_wdata),
      .bus_rdata   (mem_rdata_i),
      .byte_en     (w_be),
      .bus_wdata   (w_wdata),
      .load_data   (w_load_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= c_ST_IDLE;
         r_we         <= 1'b0;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_addr       <= 32'h0000_0000;
         r_wdata      <= 32'h0000_0000;
         r_fault_code <= 2'b00;
         r_rdata      <= 32'h0000_0000;
         r_count      <= 16'h0000;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (req_i) begin
                  r_we         <= we_i;
                  r_size       <= size_i;
                  r_unsigned   <= unsigned_i;
                  r_addr       <= address_i;
                  r_wdata      <= wdata_i;
                  r_fault_code <= w_fault_code;
                  r_rdata      <= 32'h0000_0000;
                  r_count      <= 16'h0000;
                  r_state      <= (w_fault_code != NONE) ? c_ST_RESP : c_ST_REQ;
               end
            end
            c_ST_REQ: begin
               r_count <= r_count + 16'd1;
               // A response in the final budgeted cycle still wins over the timeout.
               if (mem_gnt_i && mem_rvalid_i) begin
                  r_state <= c_ST_RESP;
                  if (!r_we) begin
                     r_rdata <= w_load_data;
                  end
               end else if (r_count == c_TIMEOUT_LAST) begin
                  r_state      <= c_ST_RESP;
                  r_fault_code <= TIMEOUT;
               end else if (mem_gnt_i) begin
                  r_state <= c_ST_WAIT;
               end
            end
            c_ST_WAIT: begin
               r_count <= r_count + 16'd1;
               if (mem_rvalid_i) begin
                  r_state <= c_ST_RESP;
                  if (!r_we) begin
                     r_rdata <= w_load_data;
                  end
               end else if (r_count == c_TIMEOUT_LAST) begin
                  r_state      <= c_ST_RESP;
                  r_fault_code <= TIMEOUT;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o       = (r_state != c_ST_IDLE);
   assign done_o       = (r_state == c_ST_RESP);
   assign fault_o      = done_o && (r_fault_code != NONE);
   assign fault_code_o = done_o ? r_fault_code : 2'b00;
   assign rdata_o      = done_o ? r_rdata : 32'h0000_0000;

   assign mem_req_o    = (r_state == c_ST_REQ);
   assign mem_we_o     = mem_req_o & r_we;
   assign mem_be_o     = mem_req_o ? w_be : 4'b0000;
   assign mem_addr_o   = mem_req_o ? {r_addr[31:2], 2'b00} : 32'h0000_0000;
   assign mem_wdata_o  = (mem_req_o && r_we) ? w_wdata : 32'h0000_0000;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_access_unit                                               |
// | Table, random and hand-written sequences against a lane model.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_i, we_i, unsigned_i, mmu_exception_i;
   logic [1:0]  size_i;
   logic [31:0] address_i, wdata_i;
   logic        busy_o, done_o, fault_o;
   logic [1:0]  fault_code_o;
   logic [31:0] rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .address_i(address_i), .mmu_exception_i(mmu_exception_i),
      .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
      .fault_code_o(fault_code_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic        mmu;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] bus;
      int          gd;      // grant in the gd-th cycle after acceptance (0 = first REQ cycle)
      int          rd;      // response rd cycles after grant
      logic [1:0]  e_code;
      logic [31:0] e_rdata;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      int          e_lat;
      int          e_reqs;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp_v);
      end
   endtask

   function automatic vec_t model(input vec_t v);
      vec_t        r = v;
      int          n = 1 << v.size;
      int          off = int'(v.addr[1:0]);
      logic        mis = (v.size == 2'b11) || ((v.addr % n) != 0);
      logic [31:0] sh;
      r.e_addr  = v.addr & 32'hFFFF_FFFC;
      r.e_be    = 4'b0000;
      for (int i = 0; i < 4; i++) r.e_be[i] = (i >= off) && (i < off + n);
      r.e_wdata = 32'h0;
      if (v.we) begin
         if (n == 1)      r.e_wdata = {4{v.wdata[7:0]}};
         else if (n == 2) r.e_wdata = {2{v.wdata[15:0]}};
         else             r.e_wdata = v.wdata;
      end
      r.e_rdata = 32'h0;
      if (v.mmu) begin
         r.e_code = 2'd1; r.e_lat = 1; r.e_reqs = 0;
      end else if (mis) begin
         r.e_code = 2'd2; r.e_lat = 1; r.e_reqs = 0;
      end else if (v.gd + v.rd <= TO - 1) begin
         r.e_code = 2'd0; r.e_lat = v.gd + v.rd + 2; r.e_reqs = v.gd + 1;
         if (!v.we) begin
            sh = v.bus >> (8 * off);
            if (n == 1)      r.e_rdata = v.uns ? {24'h0, sh[7:0]}  : 32'($signed(sh[7:0]));
            else if (n == 2) r.e_rdata = v.uns ? {16'h0, sh[15:0]} : 32'($signed(sh[15:0]));
            else             r.e_rdata = sh;
         end
      end else begin
         r.e_code = 2'd3; r.e_lat = TO + 1;
         r.e_reqs = (v.gd + 1 < TO) ? v.gd + 1 : TO;
      end
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int          lat = -1;
      int          dones = 0;
      int          reqs = 0;
      logic [1:0]  code = 2'b00;
      logic [31:0] rdv = 32'h0;
      logic        flt = 1'b0;
      logic        busy_bad = 1'b0, life_bad = 1'b0, stable_bad = 1'b0;
      logic [3:0]  f_be = 4'h0;
      logic [31:0] f_addr = 32'h0, f_wdata = 32'h0;
      logic        f_we = 1'b0;
      @(negedge clk);
      req_i = 1'b1; we_i = v.we; size_i = v.size; unsigned_i = v.uns;
      mmu_exception_i = v.mmu; address_i = v.addr; wdata_i = v.wdata;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_i = 1'b0; we_i = 1'($urandom); size_i = 2'($urandom);
            unsigned_i = 1'($urandom); mmu_exception_i = 1'($urandom);
            address_i = $urandom; wdata_i = $urandom;
         end
         if (busy_o !== (dones == 0)) busy_bad = 1'b1;
         if (done_o) begin
            if (dones == 0) begin
               lat = k; code = fault_code_o; rdv = rdata_o; flt = fault_o;
            end
            dones++;
         end else if (fault_o || fault_code_o != 2'b00 || rdata_o != 32'h0) begin
            life_bad = 1'b1;
         end
         if (mem_req_o) begin
            if (reqs == 0) begin
               f_be = mem_be_o; f_addr = mem_addr_o; f_wdata = mem_wdata_o; f_we = mem_we_o;
            end else if (mem_be_o != f_be || mem_addr_o != f_addr ||
                         mem_wdata_o != f_wdata || mem_we_o != f_we) begin
               stable_bad = 1'b1;
            end
            reqs++;
         end
         mem_gnt_i    = (k == v.gd + 1);
         mem_rvalid_i = (k == v.gd + v.rd + 1);
         mem_rdata_i  = mem_rvalid_i ? v.bus : $urandom;
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(v.e_lat));
      check({tag, " fault_code"}, 32'(code), 32'(v.e_code));
      check({tag, " fault_o"}, 32'(flt), 32'(v.e_code != 2'b00));
      check({tag, " rdata"}, rdv, v.e_rdata);
      check({tag, " done_count"}, 32'(dones), 32'd1);
      check({tag, " req_cycles"}, 32'(reqs), 32'(v.e_reqs));
      check({tag, " busy_shape"}, 32'(busy_bad), 32'd0);
      check({tag, " idle_outputs_zero"}, 32'(life_bad), 32'd0);
      if (v.e_reqs > 0) begin
         check({tag, " mem_be"}, 32'(f_be), 32'(v.e_be));
         check({tag, " mem_addr"}, f_addr, v.e_addr);
         check({tag, " mem_wdata"}, f_wdata, v.e_wdata);
         check({tag, " mem_we"}, 32'(f_we), 32'(v.we));
         check({tag, " req_stable"}, 32'(stable_bad), 32'd0);
      end
   endtask

   vec_t tbl[13];
   vec_t rv;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1);
   end

   initial begin
      int          dpos[$];
      int          dcount;
      logic        g_prev;
      // Order: we,size,uns,mmu,addr,wdata,bus,gd,rd, code,rdata,be,addr,wdata,lat,reqs
      tbl[0]  = '{0, 2'd0, 0, 0, 32'h1003, 32'h0, 32'h80FF_FF12, 0, 1, 2'd0, 32'hFFFF_FF80, 4'b1000, 32'h1000, 32'h0, 3, 1};
      tbl[1]  = '{1, 2'd1, 0, 0, 32'h2002, 32'h0000_BEEF, 32'hDEAD_DEAD, 2, 1, 2'd0, 32'h0, 4'b1100, 32'h2000, 32'hBEEF_BEEF, 5, 3};
      tbl[2]  = '{0, 2'd2, 0, 0, 32'h3001, 32'h0, 32'h0, 0, 1, 2'd2, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0};
      tbl[3]  = '{0, 2'd2, 0, 1, 32'h3001, 32'h0, 32'h0, 0, 1, 2'd1, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0};
      tbl[4]  = '{0, 2'd2, 0, 0, 32'h4000, 32'h0, 32'hCAFE_F00D, 4, 0, 2'd3, 32'h0, 4'b1111, 32'h4000, 32'h0, 5, 4};
      tbl[5]  = '{0, 2'd2, 0, 0, 32'h4004, 32'h0, 32'hCAFE_F00D, 5, 0, 2'd3, 32'h0, 4'b1111, 32'h4004, 32'h0, 5, 4};
      tbl[6]  = '{0, 2'd2, 0, 0, 32'h5000, 32'h0, 32'h1234_5678, 0, 0, 2'd0, 32'h1234_5678, 4'b1111, 32'h5000, 32'h0, 2, 1};
      tbl[7]  = '{0, 2'd1, 1, 0, 32'h6002, 32'h0, 32'h8765_4321, 0, 1, 2'd0, 32'h0000_8765, 4'b1100, 32'h6000, 32'h0, 3, 1};
      tbl[8]  = '{0, 2'd1, 0, 0, 32'h6002, 32'h0, 32'h8765_4321, 0, 1, 2'd0, 32'hFFFF_8765, 4'b1100, 32'h6000, 32'h0, 3, 1};
      tbl[9]  = '{1, 2'd0, 0, 0, 32'h7001, 32'h0000_00AB, 32'h0, 1, 2, 2'd0, 32'h0, 4'b0010, 32'h7000, 32'hABAB_ABAB, 5, 2};
      tbl[10] = '{0, 2'd3, 0, 0, 32'h7000, 32'h0, 32'h0, 0, 1, 2'd2, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0};
      tbl[11] = '{0, 2'd0, 1, 0, 32'h8001, 32'h0, 32'h0000_9A00, 0, 3, 2'd0, 32'h0000_009A, 4'b0010, 32'h8000, 32'h0, 5, 1};
      tbl[12] = '{0, 2'd3, 0, 1, 32'h9003, 32'h0, 32'h0, 0, 1, 2'd1, 32'h0, 4'b0000, 32'h0, 32'h0, 1, 0};

      reset = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
      mmu_exception_i = 1'b0; address_i = 32'h0; wdata_i = 32'h0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset control outputs", {27'h0, busy_o, done_o, fault_o, mem_req_o, mem_we_o}, 32'h0);
      check("reset data outputs", rdata_o | mem_addr_o | mem_wdata_o | {28'h0, mem_be_o} | {30'h0, fault_code_o}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("table%0d", i));

      // Back-to-back: req_i held high, immediate-grant bus, response one cycle later.
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; unsigned_i = 1'b0; mmu_exception_i = 1'b0;
      address_i = 32'h0000_0100; g_prev = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (done_o) dpos.push_back(c);
         if (c == 7) req_i = 1'b0;
         mem_rvalid_i = g_prev;
         mem_gnt_i    = mem_req_o;
         g_prev       = mem_gnt_i;
         mem_rdata_i  = 32'h0000_0100 * c;
      end
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      check("b2b done count", 32'(dpos.size()), 32'd2);
      check("b2b first done cycle", 32'((dpos.size() > 0) ? dpos[0] : -1), 32'd3);
      check("b2b second done cycle", 32'((dpos.size() > 1) ? dpos[1] : -1), 32'd7);

      // Reset pulsed while waiting for the response.
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; address_i = 32'h0000_0200;
      @(negedge clk);
      req_i = 1'b0; mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      check("wait state busy", {30'h0, busy_o, mem_req_o}, 32'h2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("post-reset control outputs", {27'h0, busy_o, done_o, fault_o, mem_req_o, mem_we_o}, 32'h0);
      check("post-reset data outputs", rdata_o | mem_addr_o | {28'h0, mem_be_o} | {30'h0, fault_code_o}, 32'h0);
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
      dcount = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         mem_rvalid_i = 1'b0;
         if (done_o) dcount++;
      end
      check("no done after reset", 32'(dcount), 32'd0);

      for (int i = 0; i < 300; i++) begin
         rv.we    = 1'($urandom);
         rv.size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rv.uns   = 1'($urandom);
         rv.mmu   = ($urandom_range(0, 7) == 0);
         rv.addr  = $urandom;
         if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
         rv.wdata = $urandom;
         rv.bus   = $urandom;
         rv.gd    = int'($urandom_range(0, 5));
         rv.rd    = int'($urandom_range(0, 3));
         rv = model(rv);
         run_vec(rv, $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
